// File: rtl/multimode_shift_register_if.sv
// Handshake and data bundle for multimode_shift_register.
// The master drives the request side; the slave (the shifter) drives status and data.
interface multimode_shift_register_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             START;
  logic [2:0]       MODE;
  logic [CNT_W-1:0] AMT;
  logic             SER_IN;
  logic [WIDTH-1:0] S_bus;
  logic [WIDTH-1:0] Q;
  logic             C;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, MODE, AMT, SER_IN, S_bus,
    input  Q, C, BUSY, DONE
  );

  modport slave (
    input  START, MODE, AMT, SER_IN, S_bus,
    output Q, C, BUSY, DONE
  );
endinterface

// File: rtl/multimode_shift_register.sv
// Multimode shift register: load, clear, logical/arithmetic shifts and rotates.
// Multi-bit shifts run one bit per cycle under a small IDLE/RUN/FIN controller.
// Every output comes straight from a register.
module multimode_shift_register #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic                      CLK,
  input logic                      CLR,
  multimode_shift_register_if.slave sr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_LOAD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_SAR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ZERO = 3'b110,
    M_NOP  = 3'b111
  } mode_t;

  state_t           state;
  mode_t            mode_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic             c_r;
  logic             busy_r;
  logic             done_r;

  // One single-bit step of the latched operation; returns {bit_out, new_q}.
  function automatic logic [WIDTH:0] step_one(
    input mode_t            m,
    input logic [WIDTH-1:0] v,
    input logic             fill,
    input logic             cur_c
  );
    logic [WIDTH:0] r;
    r = {cur_c, v};
    case (m)
      M_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], fill};
      M_SHR:   r = {v[0], fill, v[WIDTH-1:1]};
      M_SAR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[0], v[WIDTH-1:1]};
      default: r = {cur_c, v};
    endcase
    return r;
  endfunction

  // Controller and datapath: accept requests in IDLE, step once per cycle in RUN,
  // pulse DONE for one cycle in FIN.
  always_ff @(posedge CLK) begin
    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    if (CLR) begin
      state  <= IDLE;
      mode_r <= M_NOP;
      cnt    <= '0;
      q_r    <= '0;
      c_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (sr.START) begin
            mode_r <= mode_t'(sr.MODE);
            case (mode_t'(sr.MODE))
              M_LOAD: begin
                q_r    <= sr.S_bus;
                c_r    <= 1'b0;
                done_r <= 1'b1;
                state  <= FIN;
              end
              M_ZERO: begin
                q_r    <= '0;
                c_r    <= 1'b0;
                done_r <= 1'b1;
                state  <= FIN;
              end
              M_NOP: begin
                done_r <= 1'b1;
                state  <= FIN;
              end
              default: begin
                if (sr.AMT == '0) begin
                  done_r <= 1'b1;
                  state  <= FIN;
                end else begin
                  cnt    <= sr.AMT;
                  busy_r <= 1'b1;
                  state  <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          {c_r, q_r} <= step_one(mode_r, q_r, sr.SER_IN, c_r);
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign sr.Q    = q_r;
  assign sr.C    = c_r;
  assign sr.BUSY = busy_r;
  assign sr.DONE = done_r;

endmodule

// File: tb/tb_multimode_shift_register.sv
// Directed bench for multimode_shift_register (WIDTH=16, CNT_W=5).
// Expected values are hand-computed constants.
module tb_multimode_shift_register;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  localparam logic [2:0] LOAD = 3'b000;
  localparam logic [2:0] SHL  = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] SAR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ZERO = 3'b110;
  localparam logic [2:0] NOP  = 3'b111;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  multimode_shift_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) b ();

  multimode_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .CLR (clr),
    .sr  (b)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble request inputs afterwards, wait for DONE
  // (bounded), and check BUSY length, DONE latency and the one-cycle pulse.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [CNT_W-1:0] a,
                        input logic [WIDTH-1:0] d, input logic s, input int exp_busy,
                        input bit poke);
    int busy_n;
    int ticks;
    bit got;
    b.START  = 1'b1;
    b.MODE   = m;
    b.AMT    = a;
    b.S_bus  = d;
    b.SER_IN = s;
    tick();
    b.START = 1'b0;
    b.MODE  = ~m;
    b.AMT   = ~a;
    b.S_bus = ~d;
    busy_n = 0;
    ticks  = 0;
    got    = 1'b0;
    while (!got && ticks < 200) begin
      if (b.DONE) got = 1'b1;
      else begin
        if (b.BUSY) busy_n++;
        if (poke) begin
          b.START = 1'b1;
          b.MODE  = LOAD;
          b.S_bus = 16'hDEAD;
        end
        tick();
        ticks++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_done_latency"}, 32'(ticks), 32'(exp_busy));
    tick();
    b.START = 1'b0;
    check({tag, "_done_pulse_end"}, 32'(b.DONE), 32'd0);
    check({tag, "_busy_after"}, 32'(b.BUSY), 32'd0);
  endtask

  initial begin
    bit seen_done;

    // Reset with a simultaneous START that must be discarded.
    clr      = 1'b1;
    b.START  = 1'b1;
    b.MODE   = LOAD;
    b.AMT    = '0;
    b.S_bus  = 16'hFFFF;
    b.SER_IN = 1'b0;
    tick();
    tick();
    check("rst_q", 32'(b.Q), 32'h0);
    check("rst_c", 32'(b.C), 32'h0);
    check("rst_busy", 32'(b.BUSY), 32'h0);
    check("rst_done", 32'(b.DONE), 32'h0);

    // First START right after CLR release is accepted on the next edge.
    clr = 1'b0;
    run_op("load_a5c3", LOAD, 5'd0, 16'hA5C3, 1'b0, 0, 1'b0);
    check("load_a5c3_q", 32'(b.Q), 32'hA5C3);
    check("load_a5c3_c", 32'(b.C), 32'h0);

    run_op("shl4", SHL, 5'd4, 16'h0000, 1'b1, 4, 1'b0);
    check("shl4_q", 32'(b.Q), 32'h5C3F);
    check("shl4_c", 32'(b.C), 32'h0);

    run_op("load_8001", LOAD, 5'd0, 16'h8001, 1'b0, 0, 1'b0);
    run_op("sar3", SAR, 5'd3, 16'h0000, 1'b0, 3, 1'b0);
    check("sar3_q", 32'(b.Q), 32'hF000);
    check("sar3_c", 32'(b.C), 32'h0);

    // Rotate beyond WIDTH with extra STARTs pulsed through RUN and FIN.
    run_op("load_0001", LOAD, 5'd0, 16'h0001, 1'b0, 0, 1'b0);
    run_op("ror20", ROR, 5'd20, 16'h0000, 1'b0, 20, 1'b1);
    check("ror20_q", 32'(b.Q), 32'h1000);
    check("ror20_c", 32'(b.C), 32'h0);

    // Abort a SHR mid-run with CLR.
    run_op("load_ffff", LOAD, 5'd0, 16'hFFFF, 1'b0, 0, 1'b0);
    b.START  = 1'b1;
    b.MODE   = SHR;
    b.AMT    = 5'd8;
    b.SER_IN = 1'b0;
    tick();
    b.START = 1'b0;
    tick();
    tick();
    check("shr_abort_mid_q", 32'(b.Q), 32'h3FFF);
    check("shr_abort_mid_busy", 32'(b.BUSY), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_q", 32'(b.Q), 32'h0);
    check("abort_c", 32'(b.C), 32'h0);
    check("abort_busy", 32'(b.BUSY), 32'h0);
    check("abort_done", 32'(b.DONE), 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b.DONE) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 32'h0);
    run_op("load_1234", LOAD, 5'd0, 16'h1234, 1'b0, 0, 1'b0);
    check("load_1234_q", 32'(b.Q), 32'h1234);

    // Set C=1 with Q=0x00F0, then AMT=0 and NOP must keep both.
    run_op("load_01e1", LOAD, 5'd0, 16'h01E1, 1'b0, 0, 1'b0);
    run_op("shr1", SHR, 5'd1, 16'h0000, 1'b0, 1, 1'b0);
    check("shr1_q", 32'(b.Q), 32'h00F0);
    check("shr1_c", 32'(b.C), 32'h1);
    run_op("rol0", ROL, 5'd0, 16'h0000, 1'b0, 0, 1'b0);
    check("rol0_q", 32'(b.Q), 32'h00F0);
    check("rol0_c", 32'(b.C), 32'h1);
    run_op("nop", NOP, 5'd7, 16'hBEEF, 1'b0, 0, 1'b0);
    check("nop_q", 32'(b.Q), 32'h00F0);
    check("nop_c", 32'(b.C), 32'h1);
    run_op("zero", ZERO, 5'd7, 16'hBEEF, 1'b0, 0, 1'b0);
    check("zero_q", 32'(b.Q), 32'h0);
    check("zero_c", 32'(b.C), 32'h0);

    // Maximum count: SAR saturates to the sign.
    run_op("load_8000", LOAD, 5'd0, 16'h8000, 1'b0, 0, 1'b0);
    run_op("sar31", SAR, 5'd31, 16'h0000, 1'b0, 31, 1'b0);
    check("sar31_q", 32'(b.Q), 32'hFFFF);
    check("sar31_c", 32'(b.C), 32'h1);

    // SHL past WIDTH refills completely from SER_IN.
    run_op("load_1234b", LOAD, 5'd0, 16'h1234, 1'b0, 0, 1'b0);
    run_op("shl18", SHL, 5'd18, 16'h0000, 1'b1, 18, 1'b0);
    check("shl18_q", 32'(b.Q), 32'hFFFF);
    check("shl18_c", 32'(b.C), 32'h1);

    // ROL past WIDTH wraps modulo WIDTH.
    run_op("load_8001b", LOAD, 5'd0, 16'h8001, 1'b0, 0, 1'b0);
    run_op("rol17", ROL, 5'd17, 16'h0000, 1'b0, 17, 1'b0);
    check("rol17_q", 32'(b.Q), 32'h0003);
    check("rol17_c", 32'(b.C), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multimode_shift_register.md
MULTIMODE_SHIFT_REGISTER -- requirements
Module: multimode_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data register width (>= 2).
REQ-002 SHALL have parameter CNT_W, default 5, shift-amount width (>= clog2(WIDTH)+1).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port CLR  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port MODE  input  3  operation select, latched with START.
REQ-007 SHALL have port AMT  input  CNT_W  shift/rotate count, unsigned, latched with START.
REQ-008 SHALL have port SER_IN  input  1  serial fill bit for SHL/SHR, sampled on every shift edge.
REQ-009 SHALL have port S_bus  input  WIDTH  parallel load data, sampled on the START edge.
REQ-010 SHALL have port Q  output  WIDTH  register contents.
REQ-011 SHALL have port C  output  1  last bit shifted or rotated out.
REQ-012 SHALL have port BUSY  output  1  high while in RUN.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse, high in FIN.

Function
REQ-014 SHALL decode MODE: 000 LOAD, 001 SHL, 010 SHR (logical), 011 SAR (sign-fill), 100 ROL, 101 ROR, 110 ZERO (Q<=0), 111 NOP.
REQ-015 SHALL implement FSM states IDLE, RUN, FIN, with all outputs registered.
REQ-016 On START in IDLE, SHALL latch MODE and AMT.
REQ-017 From IDLE with START, LOAD/ZERO/NOP SHALL update Q on that same edge (S_bus, 0, or unchanged) and go to FIN.
REQ-018 From IDLE with START, any shift/rotate mode with AMT=0 SHALL leave Q unchanged and go to FIN.
REQ-019 From IDLE with START, any shift/rotate mode with AMT>0 SHALL load the counter with AMT and go to RUN.
REQ-020 In RUN, each edge SHALL shift or rotate Q by exactly one bit, update C with the bit leaving Q, and decrement the counter.
REQ-021 When the counter equals 1 at an edge in RUN, SHALL perform the final shift and go to FIN on that edge.
REQ-022 A shift by N SHALL keep BUSY high for exactly N cycles, with DONE high on the cycle after the last shift.
REQ-023 FIN SHALL last one cycle, then return to IDLE.
REQ-024 Minimum spacing between accepted STARTs SHALL be N+2 cycles for shifts and 2 cycles otherwise.
REQ-025 Fill bits: SHL SHALL shift SER_IN into bit0.
REQ-026 Fill bits: SHR SHALL shift SER_IN into bit WIDTH-1.
REQ-027 Fill bits: SAR SHALL replicate bit WIDTH-1.
REQ-028 Fill bits: ROL/ROR SHALL wrap the outgoing bit into the vacated end.
REQ-029 AMT >= WIDTH SHALL NOT be clamped: the exact count of single-bit steps SHALL be executed (rotations wrap modulo WIDTH; SHL/SHR fully refill with SER_IN history; SAR saturates to sign).
REQ-030 LOAD and ZERO SHALL clear C to 0; NOP and AMT=0 SHALL leave C unchanged.
REQ-031 START while in RUN or FIN SHALL be ignored, with no queuing.
REQ-032 MODE, AMT and S_bus changes after acceptance SHALL have no effect on the current operation.

Reset
REQ-033 CLR=1 at an edge SHALL set Q=0, C=0, BUSY=0, DONE=0, counter=0 and state IDLE, with priority over START and any in-flight operation.
REQ-034 CLR asserted mid-RUN SHALL abort the operation without producing a DONE pulse.
REQ-035 START asserted on the same edge as CLR SHALL be discarded.
REQ-036 After CLR deasserts, the first START SHALL be accepted on the next edge.

Verification (WIDTH=16, CNT_W=5)
REQ-037 CLR, then START MODE=000 S_bus=0xA5C3 -> Q=0xA5C3 after 1 edge, DONE=1 for the next cycle only, BUSY never 1.
REQ-038 From Q=0xA5C3, START SHL AMT=4 SER_IN=1 -> BUSY 4 cycles, Q=0x5C3F, C=0, DONE 1 cycle after.
REQ-039 From Q=0x8001, START SAR AMT=3 -> Q=0xF000, C=0, DONE on the 4th cycle after the START edge.
REQ-040 From Q=0x0001, START ROR AMT=20 -> BUSY 20 cycles, Q=0x1000, C=0; extra STARTs pulsed during BUSY are ignored.
REQ-041 From Q=0xFFFF, START SHR AMT=8 SER_IN=0, then CLR after 2 shifts -> Q=0x0000, C=0, BUSY=0, no DONE; next START LOAD 0x1234 -> Q=0x1234.
REQ-042 START ROL AMT=0 from Q=0x00F0 -> Q unchanged, C unchanged, BUSY never 1, DONE 1 cycle.
